// File: rtl/ymux_rr_arbiter.sv
// Two-source round-robin arbiter feeding a shared yMux datapath into a
// one-entry valid/ready output register.

module yMux #(
    parameter int SIZE = 32
) (
    output logic [SIZE-1:0] z,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            c
);
    assign z = c ? b : a;
endmodule

module ymux_rr_arbiter #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_a,
    input  logic [SIZE-1:0] data_a,
    output logic            ack_a,
    input  logic            req_b,
    input  logic [SIZE-1:0] data_b,
    output logic            ack_b,
    output logic            out_valid,
    output logic [SIZE-1:0] out_data,
    output logic            out_src,
    input  logic            out_ready
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_t;

    slot_t           state, state_next;
    logic            prio;
    logic            sel;
    logic            can_load;
    logic            grant;
    logic [SIZE-1:0] mux_out;

    yMux #(.SIZE(SIZE)) u_mux (
        .z (mux_out),
        .a (data_a),
        .b (data_b),
        .c (sel)
    );

    always_comb begin
        can_load   = (state == EMPTY) || out_ready;
        sel        = (req_a && req_b) ? prio : req_b;
        grant      = (req_a || req_b) && can_load;
        ack_a      = rst_n && can_load && req_a && !sel;
        ack_b      = rst_n && can_load && req_b && sel;
        state_next = state;
        if (grant) begin
            state_next = FULL;
        end else if (state == FULL && out_ready) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Loser of the current grant becomes preferred; a lone requester also moves prio.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_src  <= 1'b0;
            prio     <= 1'b0;
        end else if (grant) begin
            out_data <= mux_out;
            out_src  <= sel;
            prio     <= ~sel;
        end
    end

    assign out_valid = (state == FULL);
endmodule

// File: tb/tb_ymux_rr_arbiter.sv
// Self-checking bench for ymux_rr_arbiter: directed scenarios then randomized
// traffic against a behavioural round-robin model.

module tb_ymux_rr_arbiter;
    localparam int SIZE = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_a, req_b, out_ready;
    logic [SIZE-1:0] data_a, data_b;
    logic            ack_a, ack_b, out_valid, out_src;
    logic [SIZE-1:0] out_data;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Model: last_win is the source granted most recently (1 = B so A wins the first tie).
    logic            m_valid;
    logic [SIZE-1:0] m_data;
    logic            m_src;
    logic            last_win;

    always #5 clk = ~clk;

    ymux_rr_arbiter #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_a     (req_a),
        .data_a    (data_a),
        .ack_a     (ack_a),
        .req_b     (req_b),
        .data_b    (data_b),
        .ack_b     (ack_b),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid  = 1'b0;
        m_data   = '0;
        m_src    = 1'b0;
        last_win = 1'b1;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input logic ra, input logic rb, input logic [SIZE-1:0] da,
                        input logic [SIZE-1:0] db, input logic rdy);
        logic can, g, w;
        req_a = ra; req_b = rb; data_a = da; data_b = db; out_ready = rdy;
        #1;
        can = !m_valid || rdy;
        g   = (ra || rb) && can;
        w   = (ra && rb) ? ~last_win : rb;
        check("ack_a", ack_a, g && !w);
        check("ack_b", ack_b, g && w);
        check("ack_excl", ack_a && ack_b, 1'b0);
        @(posedge clk);
        if (g) begin
            m_valid  = 1'b1;
            m_data   = w ? db : da;
            m_src    = w;
            last_win = w;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        #1;
        check("out_valid", out_valid, m_valid);
        check("out_data", out_data, m_data);
        check("out_src", out_src, m_src);
        @(negedge clk);
    endtask

    logic src_seq [4];

    initial begin
        rst_n = 1'b0; req_a = 1'b1; req_b = 1'b0; out_ready = 1'b0;
        data_a = '0; data_b = '0;
        model_reset();

        // Reset then idle
        #3;
        check("rst_ack_a", ack_a, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        check("idle_data", out_data, 32'h0);

        // Single requester
        step(1'b1, 1'b0, 32'hDEADBEEF, '0, 1'b1);
        check("single_data", out_data, 32'hDEADBEEF);
        step(1'b0, 1'b0, '0, '0, 1'b1);

        // Contention from fresh reset priority: A,B,A,B
        rst_n = 1'b0; #1; rst_n = 1'b1; model_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 32'h1111_1111, 32'h2222_2222, 1'b1);
            src_seq[i] = out_src;
        end
        for (int i = 0; i < 4; i++) check("tie_seq", src_seq[i], (i % 2 == 1));

        // Backpressure after a capture from B
        step(1'b0, 1'b1, 32'h0, 32'hB0B0_B0B0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'hA5A5_A5A5, 32'h0, 1'b0);
        check("bp_hold_src", out_src, 1'b1);
        check("bp_hold_data", out_data, 32'hB0B0_B0B0);
        step(1'b1, 1'b0, 32'hA5A5_A5A5, 32'h0, 1'b1);
        check("reload_src", out_src, 1'b0);
        check("reload_valid", out_valid, 1'b1);
        check("reload_data", out_data, 32'hA5A5_A5A5);

        // Asynchronous reset between edges while full
        req_a = 1'b1; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_data", out_data, 32'h0);
        check("arst_ack_a", ack_a, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b1, 32'h3333_3333, 32'h4444_4444, 1'b1);
        check("post_rst_tie", out_src, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            step(1'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
